// File: rtl/mobius_seq_inv.sv
// mobius_seq_inv
//   Sequential GF(2) Moebius transform: converts an N-point truth table to
//   ANF coefficients by reusing one butterfly stage log2_N times on a
//   register.
//
//   The transform is an involution, so the same network also runs the
//   ANF -> truth-table direction.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    producer handshake; in_data is sampled on accept
//   in_data   [0:N-1]      truth table, bit 0 is the leftmost/MSB bit
//   out_valid / out_ready  consumer handshake
//   out_data  [0:N-1]      ANF coefficients, same ordering as in_data
//   busy                   high while stages are being applied
module mobius_seq_inv #(
    parameter int N      = 1024,
    parameter int log2_N = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:N-1] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:N-1] out_data,
    output logic         busy
);

    localparam int CW = $clog2(log2_N) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [0:N-1]  data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Butterfly stage result
    int unsigned   h;
    logic [0:N-1]  stage_mask;
    logic [0:N-1]  stage_out;

    // Indices whose bit h is set receive r[i-h]. With bit 0 as the MSB,
    // a logical right shift by h moves r[i-h] into position i.
    always_comb begin
        h          = N >> (int'(cnt_q) + 1);
        stage_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            stage_mask[i] = ((i & h) != 0);
        end
        stage_out = data_q ^ ((data_q >> h) & stage_mask);
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                data_d = stage_out;
                if (cnt_q == CW'(log2_N - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_data = data_q;

endmodule
